id_ex_pipe_reg: RTL

Parametrised ID/EX pipeline register with a valid/ready handshake, synchronous flush, and control-bubble gating. It sits between the decode stage and the execute stage, carrying operands, immediate, register indices, ALU-control bits and control signals. It replaces the free-running ID/EX register: it can hold on back-pressure, drop its contents on a branch or exception flush, and optionally decouple `in_ready` from `out_ready` through a two-entry skid buffer.

---
 rtl/id_ex_pipe_reg_if.sv | 73 +++++++
 rtl/id_ex_pipe_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: decode-to-execute handshake and payload bundle for the
// ID/EX pipeline register. The slave modport is the register itself; the
// master modport is the surrounding decode/execute logic.
interface id_ex_pipe_reg_if #(
    parameter int XLEN = 64,
    parameter int REGW = 5
);
    // Decode side
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] rs1_data_in;
    logic [XLEN-1:0] rs2_data_in;
    logic [XLEN-1:0] imm_in;
    logic [REGW-1:0] rd_in;
    logic [REGW-1:0] rs1_in;
    logic [REGW-1:0] rs2_in;
    logic [31:0]     instr_in;
    logic            branch_in;
    logic            memread_in;
    logic            memtoreg_in;
    logic            memwrite_in;
    logic            alusrc_in;
    logic            regwrite_in;
    logic [1:0]      aluop_in;

    // Execute side
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] pc_ex;
    logic [XLEN-1:0] rs1_data_ex;
    logic [XLEN-1:0] rs2_data_ex;
    logic [XLEN-1:0] imm_ex;
    logic [REGW-1:0] rd_ex;
    logic [REGW-1:0] rs1_ex;
    logic [REGW-1:0] rs2_ex;
    logic [3:0]      funct_ex;
    logic            branch_ex;
    logic            memread_ex;
    logic            memtoreg_ex;
    logic            memwrite_ex;
    logic            alusrc_ex;
    logic            regwrite_ex;
    logic [1:0]      aluop_ex;
    logic [1:0]      occupancy;

    modport master (
        output in_valid, flush, out_ready,
        output pc_in, rs1_data_in, rs2_data_in, imm_in,
        output rd_in, rs1_in, rs2_in, instr_in,
        output branch_in, memread_in, memtoreg_in, memwrite_in,
        output alusrc_in, regwrite_in, aluop_in,
        input  in_ready, out_valid, occupancy,
        input  pc_ex, rs1_data_ex, rs2_data_ex, imm_ex,
        input  rd_ex, rs1_ex, rs2_ex, funct_ex,
        input  branch_ex, memread_ex, memtoreg_ex, memwrite_ex,
        input  alusrc_ex, regwrite_ex, aluop_ex
    );

    modport slave (
        input  in_valid, flush, out_ready,
        input  pc_in, rs1_data_in, rs2_data_in, imm_in,
        input  rd_in, rs1_in, rs2_in, instr_in,
        input  branch_in, memread_in, memtoreg_in, memwrite_in,
        input  alusrc_in, regwrite_in, aluop_in,
        output in_ready, out_valid, occupancy,
        output pc_ex, rs1_data_ex, rs2_data_ex, imm_ex,
        output rd_ex, rs1_ex, rs2_ex, funct_ex,
        output branch_ex, memread_ex, memtoreg_ex, memwrite_ex,
        output alusrc_ex, regwrite_ex, aluop_ex
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with valid/ready handshake,
// synchronous flush and bubble gating of the side-effecting controls.
// Build option: define IDEX_SKID_EN to add a second (skid) entry so that
// in_ready is a registered signal with no combinational path from out_ready.
// Without it the block is a single register and in_ready = !out_valid || out_ready.
module id_ex_pipe_reg #(
    parameter int XLEN = 64,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    id_ex_pipe_reg_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rd;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [3:0]      funct;
        logic            branch;
        logic            memread;
        logic            memtoreg;
        logic            memwrite;
        logic            alusrc;
        logic            regwrite;
        logic [1:0]      aluop;
    } idex_t;

    // Occupancy encoding doubles as the handshake state.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;

    logic [1:0] state_q;
    logic [1:0] state_d;
    idex_t      in_pkt;
    idex_t      out_q;
    idex_t      out_d;
    logic       out_valid;
    logic       in_ready;
    logic       accept;
    logic       deliver;
    logic       unused_instr;

    // Pack the decode payload; only bit 30 and bits 14:12 of the instruction survive.
    always_comb begin
        in_pkt          = '0;
        in_pkt.pc       = bus.pc_in;
        in_pkt.rs1_data = bus.rs1_data_in;
        in_pkt.rs2_data = bus.rs2_data_in;
        in_pkt.imm      = bus.imm_in;
        in_pkt.rd       = bus.rd_in;
        in_pkt.rs1      = bus.rs1_in;
        in_pkt.rs2      = bus.rs2_in;
        in_pkt.funct    = {bus.instr_in[30], bus.instr_in[14:12]};
        in_pkt.branch   = bus.branch_in;
        in_pkt.memread  = bus.memread_in;
        in_pkt.memtoreg = bus.memtoreg_in;
        in_pkt.memwrite = bus.memwrite_in;
        in_pkt.alusrc   = bus.alusrc_in;
        in_pkt.regwrite = bus.regwrite_in;
        in_pkt.aluop    = bus.aluop_in;
    end

    assign unused_instr = ^{bus.instr_in[31], bus.instr_in[29:15], bus.instr_in[11:0]};

    assign out_valid = (state_q != ST_EMPTY);
    assign deliver   = out_valid && bus.out_ready;
    assign accept    = bus.in_valid && in_ready && !bus.flush;

`ifdef IDEX_SKID_EN
    localparam logic [1:0] ST_FULL = 2'd2;

    idex_t skid_q;
    idex_t skid_d;

    // Ready depends only on the state register, breaking the out_ready path.
    assign in_ready = (state_q != ST_FULL);

    // Occupancy transitions; flush empties both entries regardless of handshakes.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_ONE;
                ST_ONE: begin
                    if (accept && !deliver) begin
                        state_d = ST_FULL;
                    end else if (!accept && deliver) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL:  if (deliver) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Steer payload: new data goes to the output register when it is free or
    // draining, otherwise into the skid entry; a draining FULL promotes skid.
    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        if (!bus.flush) begin
            case (state_q)
                ST_EMPTY: if (accept) out_d = in_pkt;
                ST_ONE: begin
                    if (accept && deliver) begin
                        out_d = in_pkt;
                    end else if (accept) begin
                        skid_d = in_pkt;
                    end
                end
                ST_FULL:  if (deliver) out_d = skid_q;
                default:  out_d = out_q;
            endcase
        end
    end

    // Skid entry storage; its validity is encoded in state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_q <= '0;
        end else begin
            skid_q <= skid_d;
        end
    end

    assign bus.occupancy = state_q;
`else
    // Single entry: accept whenever the register is free or being drained.
    assign in_ready = !out_valid || bus.out_ready;

    // Occupancy transitions; an accept always refills the draining register.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_ONE;
                ST_ONE:   if (deliver && !accept) state_d = ST_EMPTY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Load the output register on every accept; flush leaves payload untouched.
    always_comb begin
        out_d = out_q;
        if (accept) begin
            out_d = in_pkt;
        end
    end

    assign bus.occupancy = {1'b0, state_q[0]};
`endif

    // Handshake state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output payload register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.pc_ex       = out_q.pc;
    assign bus.rs1_data_ex = out_q.rs1_data;
    assign bus.rs2_data_ex = out_q.rs2_data;
    assign bus.imm_ex      = out_q.imm;
    assign bus.rd_ex       = out_q.rd;
    assign bus.rs1_ex      = out_q.rs1;
    assign bus.rs2_ex      = out_q.rs2;
    assign bus.funct_ex    = out_q.funct;
    assign bus.memtoreg_ex = out_q.memtoreg;
    assign bus.alusrc_ex   = out_q.alusrc;
    assign bus.aluop_ex    = out_q.aluop;

    // Bubbles must never branch, touch memory or write the register file.
    assign bus.branch_ex   = out_q.branch   && out_valid;
    assign bus.memread_ex  = out_q.memread  && out_valid;
    assign bus.memwrite_ex = out_q.memwrite && out_valid;
    assign bus.regwrite_ex = out_q.regwrite && out_valid;
endmodule
